// File: rtl/fp16_normalize_pack.sv
// fp16_normalize_pack: normalizes the signed 12-bit mantissa sum from the FP16 adder and
// packs it into an IEEE-754 binary16 word, one shift per cycle, valid/ready on both sides.
// Optional build macro: FP16_RNE_EN (round-to-nearest-even on the carry right-shift;
// truncation when undefined).
module fp16_normalize_pack #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned FRAC_W = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sign,
  input  logic [EXP_W-1:0]             in_exp,
  input  logic [FRAC_W+1:0]            in_mant,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_W+FRAC_W:0]        out_result,
  output logic                         out_overflow,
  output logic                         out_zero
);

  localparam int unsigned MANT_W = FRAC_W + 2;
  localparam int unsigned IEXP_W = EXP_W + 1;
  localparam int unsigned RES_W  = EXP_W + FRAC_W + 1;
  localparam logic [IEXP_W-1:0] EXP_ONE = IEXP_W'(1);
  localparam logic [IEXP_W-1:0] EXP_INF = IEXP_W'((2 ** EXP_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CARRY,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [RES_W-1:0]     result_q;
  logic                 overflow_q;
  logic                 zero_q;
  logic                 sign_q;
  logic [IEXP_W-1:0]    exp_q;
  logic [MANT_W-1:0]    mant_q;

  logic [IEXP_W-1:0]    in_exp_d;
  logic [MANT_W-1:0]    carry_mant_d;
  logic [IEXP_W-1:0]    carry_exp_d;
  logic [MANT_W-1:0]    shift_mant_d;
  logic [IEXP_W-1:0]    shift_exp_d;

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_result   = result_q;
  assign out_overflow = overflow_q;
  assign out_zero     = zero_q;

  // Input exponent widened by one bit; a zero exponent behaves as 1.
  always_comb begin
    in_exp_d = (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
  end

  // Carry step: right shift by one with optional round-to-nearest-even of the dropped bit.
  always_comb begin
    carry_mant_d = mant_q >> 1;
    carry_exp_d  = exp_q + EXP_ONE;
`ifdef FP16_RNE_EN
    if (mant_q[0] && carry_mant_d[0]) begin
      carry_mant_d = carry_mant_d + MANT_W'(1);
      // Rounding carried into bit 11: renormalize in the same cycle.
      if (carry_mant_d[MANT_W-1]) begin
        carry_mant_d = carry_mant_d >> 1;
        carry_exp_d  = carry_exp_d + EXP_ONE;
      end
    end
`endif
  end

  // Left-normalize step: one position per cycle.
  always_comb begin
    shift_mant_d = mant_q << 1;
    shift_exp_d  = exp_q - EXP_ONE;
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sign_q     <= in_sign;
            exp_q      <= in_exp_d;
            mant_q     <= in_mant;
            in_ready_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            if (in_mant == '0) begin
              result_q    <= '0;
              zero_q      <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (in_exp_d == EXP_INF) begin
              result_q    <= {in_sign, EXP_INF[EXP_W-1:0], FRAC_W'(0)};
              overflow_q  <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (in_mant[MANT_W-1]) begin
              state_q <= S_CARRY;
            end else if (in_mant[FRAC_W]) begin
              result_q    <= {in_sign, in_exp_d[EXP_W-1:0], in_mant[FRAC_W-1:0]};
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_SHIFT;
            end
          end
        end

        S_CARRY: begin
          mant_q      <= carry_mant_d;
          exp_q       <= carry_exp_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
          if (carry_exp_d >= EXP_INF) begin
            result_q   <= {sign_q, EXP_INF[EXP_W-1:0], FRAC_W'(0)};
            overflow_q <= 1'b1;
          end else begin
            result_q <= {sign_q, carry_exp_d[EXP_W-1:0], carry_mant_d[FRAC_W-1:0]};
          end
        end

        S_SHIFT: begin
          if (exp_q == EXP_ONE) begin
            // Entered at the minimum exponent: no room to shift, emit subnormal as is.
            result_q    <= {sign_q, EXP_W'(0), mant_q[FRAC_W-1:0]};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            mant_q <= shift_mant_d;
            exp_q  <= shift_exp_d;
            if (shift_mant_d[FRAC_W]) begin
              result_q    <= {sign_q, shift_exp_d[EXP_W-1:0], shift_mant_d[FRAC_W-1:0]};
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (shift_exp_d == EXP_ONE) begin
              result_q    <= {sign_q, EXP_W'(0), shift_mant_d[FRAC_W-1:0]};
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_normalize_pack.sv
// Directed testbench for fp16_normalize_pack: hand-computed binary16 results, latencies,
// flags, back-pressure stability and asynchronous reset behaviour.
module tb_fp16_normalize_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [11:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_overflow;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  fp16_normalize_pack dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_zero     (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issue one operation, measure latency (accepting edge counts as cycle 1), check result,
  // optionally hold out_ready low for 'hold' cycles, then accept the result.
  task automatic run_op(input string tag, input logic s, input logic [4:0] e,
                        input logic [11:0] m, input logic [15:0] exp_res,
                        input logic exp_ovf, input logic exp_zero,
                        input int exp_lat, input int hold);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mant  = 12'hFFF;
    in_exp   = 5'h1F;
    lat      = 1;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_res"}, 32'(out_result), 32'(exp_res));
    check({tag, "_ovf"}, 32'(out_overflow), 32'(exp_ovf));
    check({tag, "_zero"}, 32'(out_zero), 32'(exp_zero));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_res"}, 32'(out_result), 32'(exp_res));
      check({tag, "_hold_flags"}, 32'({out_overflow, out_zero}), 32'({exp_ovf, exp_zero}));
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_flags", 32'({out_overflow, out_zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);

    // Already normalized, then carry.
    run_op("t1a", 1'b0, 5'd15, 12'h400, 16'h3C00, 1'b0, 1'b0, 1, 0);
    run_op("t1b", 1'b0, 5'd15, 12'h800, 16'h4000, 1'b0, 1'b0, 2, 0);
    // Ten normalize shifts.
    run_op("t2", 1'b0, 5'd15, 12'h001, 16'h1400, 1'b0, 1'b0, 11, 0);
    // Zero (sign forced positive) and subnormal.
    run_op("t3a", 1'b1, 5'd9, 12'h000, 16'h0000, 1'b0, 1'b1, 1, 0);
    run_op("t3b", 1'b0, 5'd2, 12'h080, 16'h0100, 1'b0, 1'b0, 2, 0);
    // Carry into infinity, both signs.
    run_op("t4a", 1'b0, 5'd30, 12'h800, 16'h7C00, 1'b1, 1'b0, 2, 0);
    run_op("t4b", 1'b1, 5'd30, 12'h800, 16'hFC00, 1'b1, 1'b0, 2, 0);
    // Input exponent already all-ones.
    run_op("t4c", 1'b0, 5'd31, 12'h400, 16'h7C00, 1'b1, 1'b0, 1, 0);
    // Rounding of the dropped carry bit.
`ifdef FP16_RNE_EN
    run_op("t5a", 1'b0, 5'd15, 12'hC03, 16'h4202, 1'b0, 1'b0, 2, 0);
    run_op("t5b", 1'b0, 5'd15, 12'hFFF, 16'h4400, 1'b0, 1'b0, 2, 0);
`else
    run_op("t5a", 1'b0, 5'd15, 12'hC03, 16'h4201, 1'b0, 1'b0, 2, 0);
    run_op("t5b", 1'b0, 5'd15, 12'hFFF, 16'h43FF, 1'b0, 1'b0, 2, 0);
`endif
    run_op("t5c", 1'b0, 5'd15, 12'hC01, 16'h4200, 1'b0, 1'b0, 2, 0);
    // Exponent 0 behaves as 1; minimum exponent with unnormalized mantissa.
    run_op("t7a", 1'b0, 5'd0, 12'h400, 16'h0400, 1'b0, 1'b0, 1, 0);
    run_op("t7b", 1'b1, 5'd1, 12'h0FF, 16'h80FF, 1'b0, 1'b0, 2, 0);
    // Back-pressure: result held for three cycles.
    run_op("t6", 1'b1, 5'd15, 12'h400, 16'hBC00, 1'b0, 1'b0, 1, 3);

    // Reset pulse in the middle of a SHIFT sequence.
    @(negedge clk);
    in_sign  = 1'b0;
    in_exp   = 5'd15;
    in_mant  = 12'h001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rs_busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_result", 32'(out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rs_ready", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("rs_no_ghost", 32'(out_valid), 32'd0);

    // Reset pulse while a result waits in DONE.
    @(negedge clk);
    in_sign  = 1'b0;
    in_exp   = 5'd15;
    in_mant  = 12'h400;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rd_valid_pre", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rd_valid", 32'(out_valid), 32'd0);
    check("rd_flags", 32'({out_overflow, out_zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rd_ready", 32'(in_ready), 32'd1);

    // Recovery after reset.
    run_op("rec", 1'b0, 5'd20, 12'h200, 16'h4C00, 1'b0, 1'b0, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
